// File: rtl/c17_bist.sv
// BIST wrapper for the c17 netlist: 5-bit LFSR stimulus, 16-bit MISR response compaction, golden compare.
// Optional abort input enabled by defining C17_BIST_ABORT_EN.
module c17_bist #(
  parameter int          PAT_COUNT = 31,
  parameter logic [4:0]  SEED      = 5'b00001,
  parameter logic [15:0] GOLDEN    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
`ifdef C17_BIST_ABORT_EN
  input  logic        abort,
`endif
  output logic [4:0]  pat,
  input  logic [1:0]  resp,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [4:0]  pat_idx
);

  // An all-zero seed would lock the LFSR, so it is quietly replaced.
  localparam logic [4:0] SEED_EFF = (SEED == 5'd0) ? 5'd1 : SEED;
  localparam logic [4:0] LAST_IDX = 5'(PAT_COUNT - 1);

  typedef enum logic [1:0] {IDLE, RUN, COMPARE, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  pat_q, pat_d;
  logic [4:0]  idx_q, idx_d;
  logic [15:0] sig_q, sig_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        abort_req;

`ifdef C17_BIST_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [1:0] r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'b0, r};
  endfunction

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    sig_d   = sig_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          pat_d   = SEED_EFF;
          sig_d   = 16'h0000;
          idx_d   = 5'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        if (abort_req) begin
          state_d = IDLE;
          pat_d   = 5'd0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          sig_d = misr_step(sig_q, resp);
          pat_d = {pat_q[3:0], pat_q[4] ^ pat_q[2]};
          idx_d = idx_q + 5'd1;
          // The last response has been captured above; park the CUT inputs at zero.
          if (idx_q == LAST_IDX) begin
            pat_d   = 5'd0;
            state_d = COMPARE;
          end
        end
      end
      COMPARE: begin
        if (abort_req) begin
          state_d = IDLE;
          pat_d   = 5'd0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          pass_d  = (sig_q == GOLDEN);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= 5'd0;
      idx_q   <= 5'd0;
      sig_q   <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign pat       = pat_q;
  assign pat_idx   = idx_q;
  assign signature = sig_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_c17_bist.sv
// Self-checking bench for c17_bist: a behavioural c17 + LFSR + MISR model predicts every cycle of each run.
// Abort scenarios are exercised only when C17_BIST_ABORT_EN is defined.
module tb_c17_bist;

   localparam int PC = 31;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [4:0]  pat;
   logic [1:0]  resp;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] signature;
   logic [4:0]  pat_idx;

   int tests = 0;
   int fails = 0;

   // Response source: 0 = tied low, 1 = good c17, 2 = c17 with N22 stuck-at-0, 3 = random lookup table
   int         mode;
   logic [1:0] lut [32];

   logic [4:0]  expPat [32];
   logic [15:0] expSig [32];
   logic [4:0]  obsPat [32];

   // Plain boolean form of the six-NAND c17 netlist; pattern bits are {N1,N2,N3,N6,N7}
   function automatic logic [1:0] c17(input logic [4:0] p);
      logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
      n1 = p[4]; n2 = p[3]; n3 = p[2]; n6 = p[1]; n7 = p[0];
      n10 = ~(n1 & n3);
      n11 = ~(n3 & n6);
      n16 = ~(n2 & n11);
      n19 = ~(n11 & n7);
      return {~(n10 & n16), ~(n16 & n19)};
   endfunction

   // LFSR successor written as integer arithmetic: shift left, feed back bit4 xor bit2
   function automatic logic [4:0] lfsrStep(input logic [4:0] p);
      int v, fb, nx;
      v  = int'(p);
      fb = ((v / 16) ^ (v / 4)) % 2;
      nx = (v * 2) % 32 + fb;
      return 5'(nx);
   endfunction

   // MISR successor: multiply by x modulo the CRC polynomial, then add the response
   function automatic logic [15:0] misrStep(input logic [15:0] s, input logic [1:0] r);
      int v;
      v = (int'(s) * 2) % 65536;
      if (int'(s) >= 32768) v = v ^ 32'h1021;
      v = v ^ int'(r);
      return 16'(v);
   endfunction

   function automatic logic [15:0] calcGolden();
      logic [4:0]  p;
      logic [15:0] s;
      p = 5'b00001;
      s = 16'h0000;
      for (int k = 0; k < PC; k++) begin
         s = misrStep(s, c17(p));
         p = lfsrStep(p);
      end
      return s;
   endfunction

   localparam logic [15:0] GOLD = calcGolden();

   function automatic logic [1:0] modelResp(input int m, input logic [4:0] p);
      logic [1:0] r;
      r = c17(p);
      case (m)
         0:       return 2'b00;
         1:       return r;
         2:       return r & 2'b01;
         default: return lut[p];
      endcase
   endfunction

   // The CUT stand-in is purely combinational from pat
   always_comb resp = modelResp(mode, pat);

   c17_bist #(.PAT_COUNT(PC), .SEED(5'b00001), .GOLDEN(GOLD)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
`ifdef C17_BIST_ABORT_EN
      .abort(abort),
`endif
      .pat(pat),
      .resp(resp),
      .busy(busy),
      .done(done),
      .pass(pass),
      .signature(signature),
      .pat_idx(pat_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it, and reports tag/observed/expected on a miss
   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Predicted pattern and signature after each edge of a run driven from response source m
   task automatic buildModel(input int m);
      expPat[0] = 5'b00001;
      expSig[0] = 16'h0000;
      for (int k = 1; k < 32; k++) begin
         expPat[k] = lfsrStep(expPat[k-1]);
         expSig[k] = misrStep(expSig[k-1], modelResp(m, expPat[k-1]));
      end
   endtask

   // Starts a run from a negedge and checks every cycle through done; returns the final signature
   task automatic applyStimulus(input int m, input bit hold, output logic [15:0] finalSig);
      logic [4:0]  ePat;
      logic [4:0]  eIdx;
      logic [15:0] eSig;
      logic        eBusy, eDone, ePass;
      mode = m;
      buildModel(m);
      start = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      for (int c = 0; c <= PC + 1; c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
         if (c < PC) begin
            ePat = expPat[c]; eIdx = 5'(c); eSig = expSig[c];
            eBusy = 1'b1; eDone = 1'b0; ePass = 1'b0;
            obsPat[c] = pat;
         end else if (c == PC) begin
            ePat = 5'd0; eIdx = 5'(PC); eSig = expSig[PC];
            eBusy = 1'b1; eDone = 1'b0; ePass = 1'b0;
         end else begin
            ePat = 5'd0; eIdx = 5'(PC); eSig = expSig[PC];
            eBusy = 1'b0; eDone = 1'b1; ePass = (expSig[PC] == GOLD);
         end
         checkOutput($sformatf("pat_c%0d", c), 16'(pat), 16'(ePat));
         checkOutput($sformatf("idx_c%0d", c), 16'(pat_idx), 16'(eIdx));
         checkOutput($sformatf("sig_c%0d", c), signature, eSig);
         checkOutput($sformatf("busy_c%0d", c), 16'(busy), 16'(eBusy));
         checkOutput($sformatf("done_c%0d", c), 16'(done), 16'(eDone));
         checkOutput($sformatf("pass_c%0d", c), 16'(pass), 16'(ePass));
      end
      start = 1'b0;
      finalSig = signature;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_pat"}, 16'(pat), 16'h0);
      checkOutput({tag, "_busy"}, 16'(busy), 16'h0);
      checkOutput({tag, "_done"}, 16'(done), 16'h0);
      checkOutput({tag, "_pass"}, 16'(pass), 16'h0);
      checkOutput({tag, "_sig"}, signature, 16'h0);
      checkOutput({tag, "_idx"}, 16'(pat_idx), 16'h0);
   endtask

   logic [15:0] sigA, sigB;
   logic [4:0]  first6 [6];
   bit          seen [32];
   int          distinct;

   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      mode  = 0;
      for (int i = 0; i < 32; i++) lut[i] = 2'($urandom_range(0, 3));
      first6[0] = 5'b00001; first6[1] = 5'b00010; first6[2] = 5'b00100;
      first6[3] = 5'b01001; first6[4] = 5'b10010; first6[5] = 5'b00101;

      // Reset is asynchronous: values must settle before any clock edge
      #1 rst_n = 1'b0;
      #2 checkIdle("reset_async");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkIdle("idle_after_reset");

      // Responses tied low: pattern walk, distinct-value count, zero signature
      applyStimulus(0, 1'b0, sigA);
      checkOutput("sig_tied_low", sigA, 16'h0000);
      for (int i = 0; i < 6; i++)
         checkOutput($sformatf("first_pat%0d", i), 16'(obsPat[i]), 16'(first6[i]));
      for (int i = 0; i < 32; i++) seen[i] = 1'b0;
      distinct = 0;
      for (int i = 0; i < PC; i++) begin
         if (obsPat[i] != 5'd0 && !seen[obsPat[i]]) distinct++;
         seen[obsPat[i]] = 1'b1;
      end
      checkOutput("distinct_pats", 16'(distinct), 16'd31);

      // Good c17 must match the golden signature; restart straight from DONE
      applyStimulus(1, 1'b0, sigA);
      checkOutput("good_pass", 16'(pass), 16'h1);

      // N22 stuck-at-0: signature must move away from golden
      applyStimulus(2, 1'b0, sigB);
      checkOutput("sa0_pass", 16'(pass), 16'h0);
      checkOutput("sa0_sig_differs", 16'(sigB != GOLD), 16'h1);

      // start held high all run long must not restart before done
      applyStimulus(1, 1'b1, sigB);
      checkOutput("held_start_sig", sigB, sigA);

      // Reset mid-run at pat_idx 10, then a full clean run
      mode = 1;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #2 checkOutput("pre_reset_idx", 16'(pat_idx), 16'd10);
      rst_n = 1'b0;
      #1 checkIdle("midrun_reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkIdle("midrun_reset_idle");
      applyStimulus(1, 1'b0, sigB);
      checkOutput("after_reset_sig", sigB, sigA);

`ifdef C17_BIST_ABORT_EN
      // Abort at pat_idx 7: back to IDLE with the partial signature kept for debug
      mode = 1;
      buildModel(1);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      checkOutput("pre_abort_idx", 16'(pat_idx), 16'd7);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      checkOutput("abort_busy", 16'(busy), 16'h0);
      checkOutput("abort_done", 16'(done), 16'h0);
      checkOutput("abort_pass", 16'(pass), 16'h0);
      checkOutput("abort_pat", 16'(pat), 16'h0);
      checkOutput("abort_sig", signature, expSig[7]);
      @(negedge clk);
      checkOutput("abort_stays_idle", 16'(busy), 16'h0);
      applyStimulus(1, 1'b0, sigB);
      checkOutput("after_abort_sig", sigB, sigA);
`endif

      // Randomised responses and start styles against the model
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 32; i++) lut[i] = 2'($urandom_range(0, 3));
         applyStimulus(3, 1'($urandom_range(0, 1)), sigB);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Hard ceiling so a stuck run still terminates
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation exceeded time budget");
      $fatal(1, "[TB] timeout");
   end

endmodule
